// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, 2-entry prefetch buffer with valid/ready to decode,
// redirect with flush, and halt-on-opcode stop.
module inst_fetch_unit #(
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          DATA_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [DATA_W-1:0]    HALT_OP  = '1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] inst_address,
  input  logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              stopped
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    STOPPED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  count_q;
  logic              rd_ptr_q, wr_ptr_q;
  entry_t            fifo_q [DEPTH];
  logic              pop_c, push_c;

  assign pop_c  = inst_valid & inst_ready & ~redirect;
  assign push_c = (state_q == RUN) & ~redirect & ((count_q < CNT_W'(DEPTH)) | pop_c);

  assign inst_address = pc_q;

  // PC and prefetch buffer; redirect flushes and overrides any push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (redirect) begin
      pc_q     <= redirect_pc;
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= '{pc: pc_q, data: instruction};
        wr_ptr_q         <= ~wr_ptr_q;
        pc_q             <= pc_q + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (push_c && (instruction == HALT_OP)) state_d = STOPPED;
      STOPPED: if (redirect) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Head of buffer and FSM status; data/pc read as zero when empty
  always_comb begin
    stopped    = 1'b0;
    inst_valid = 1'b0;
    inst_data  = '0;
    inst_pc    = '0;
    if (state_q == STOPPED) stopped = 1'b1;
    if (count_q != '0) begin
      inst_valid = 1'b1;
      inst_data  = fifo_q[rd_ptr_q].data;
      inst_pc    = fifo_q[rd_ptr_q].pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a combinational instruction memory model.
module tb_inst_fetch_unit;

  logic       clk;
  logic       reset;
  logic [7:0] inst_address;
  logic [7:0] instruction;
  logic       inst_valid;
  logic [7:0] inst_data;
  logic [7:0] inst_pc;
  logic       inst_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       stopped;

  logic [7:0] mem [256];
  int         n_total;
  int         n_bad;

  inst_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .inst_address (inst_address),
    .instruction  (instruction),
    .inst_valid   (inst_valid),
    .inst_data    (inst_data),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stopped      (stopped)
  );

  assign instruction = mem[inst_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] pc, input logic [7:0] data);
    check({tag, ".valid"}, 32'(inst_valid), 32'd1);
    check({tag, ".pc"},    32'(inst_pc),    32'(pc));
    check({tag, ".data"},  32'(inst_data),  32'(data));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset spans one rising edge; release lands mid-cycle
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_total     = 0;
    n_bad       = 0;
    reset       = 1'b1;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    for (int a = 0; a < 8; a++) mem[a] = 8'(a + 8'h10);

    // reset state
    #12;
    check("rst.valid", 32'(inst_valid), 32'd0);
    check("rst.addr",  32'(inst_address), 32'h00);
    check("rst.data",  32'(inst_data), 32'h00);
    check("rst.pc",    32'(inst_pc), 32'h00);
    check("rst.stop",  32'(stopped), 32'd0);

    // T1: streaming with ready held high
    do_reset();
    inst_ready = 1'b1;
    check("t1.pre_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_head($sformatf("t1.%0d", i), 8'(i), 8'(8'h10 + i));
    end

    // T2: backpressure saturates buffer, then drains in order
    do_reset();
    inst_ready = 1'b0;
    tick();
    check_head("t2.first", 8'h00, 8'h10);
    for (int i = 0; i < 5; i++) tick();
    check("t2.addr_hold", 32'(inst_address), 32'h02);
    check_head("t2.hold", 8'h00, 8'h10);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("t2.drain%0d", i), 8'(i), 8'(8'h10 + i));
      tick();
    end

    // T3: redirect while buffer holds 01,02 and ready is high
    do_reset();
    inst_ready = 1'b0;
    tick();
    tick();
    inst_ready = 1'b1;
    tick();
    check_head("t3.pre", 8'h01, 8'h11);
    redirect    = 1'b1;
    redirect_pc = 8'h05;
    tick();
    redirect = 1'b0;
    check("t3.flush_valid", 32'(inst_valid), 32'd0);
    check("t3.addr", 32'(inst_address), 32'h05);
    tick();
    check_head("t3.tgt", 8'h05, 8'h15);
    tick();
    check_head("t3.tgt1", 8'h06, 8'h16);

    // T4: halt opcode at address 3
    mem[3] = 8'hFF;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head($sformatf("t4.%0d", i), 8'(i), (i == 3) ? 8'hFF : 8'(8'h10 + i));
    end
    check("t4.stopped", 32'(stopped), 32'd1);
    check("t4.addr", 32'(inst_address), 32'h04);
    tick();
    check("t4.drained", 32'(inst_valid), 32'd0);
    tick();
    check("t4.addr_frozen", 32'(inst_address), 32'h04);
    check("t4.still_stopped", 32'(stopped), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 8'h00;
    tick();
    redirect = 1'b0;
    check("t4.resume_stop", 32'(stopped), 32'd0);
    check("t4.resume_addr", 32'(inst_address), 32'h00);
    tick();
    check_head("t4.resume", 8'h00, 8'h10);
    mem[3] = 8'h13;

    // T5: PC wrap
    mem[8'hFE] = 8'hAA;
    mem[8'hFF] = 8'hBB;
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    tick();
    check_head("t5.fe", 8'hFE, 8'hAA);
    tick();
    check_head("t5.ff", 8'hFF, 8'hBB);
    tick();
    check_head("t5.00", 8'h00, 8'h10);
    tick();
    check_head("t5.01", 8'h01, 8'h11);

    // T6: asynchronous reset pulse between edges
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6.valid", 32'(inst_valid), 32'd0);
    check("t6.addr",  32'(inst_address), 32'h00);
    check("t6.stop",  32'(stopped), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check_head("t6.0", 8'h00, 8'h10);
    tick();
    check_head("t6.1", 8'h01, 8'h11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
